// File: rtl/anabellek_hakem.sv
// anabellek_hakem: round-robin N-channel arbiter onto one iomem port.
// ANABELLEK_ZAMANASIMI_EN enables the hung-transaction timeout.
module anabellek_hakem #(
  parameter int          KANAL_SAYISI   = 2,
  parameter int          ADRES_GENISLIK = 17,
  parameter logic [31:0] TABAN_ADRES    = 32'h4000_0000,
  parameter int          ZAMANASIMI     = 255
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  output logic                                 iomem_valid,
  input  logic                                 iomem_ready,
  output logic [3:0]                           iomem_wstrb,
  output logic [31:0]                          iomem_addr,
  output logic [31:0]                          iomem_wdata,
  input  logic [31:0]                          iomem_rdata,
  input  logic                                 oncelik_valid,
  output logic                                 oncelik_ready,
  input  logic [31:0]                          oncelik_addr,
  output logic [31:0]                          oncelik_rdata,
  input  logic [KANAL_SAYISI-1:0]              kanal_valid,
  output logic [KANAL_SAYISI-1:0]              kanal_ready,
  input  logic [4*KANAL_SAYISI-1:0]            kanal_wstrb,
  input  logic [ADRES_GENISLIK*KANAL_SAYISI-1:0] kanal_addr,
  input  logic [32*KANAL_SAYISI-1:0]           kanal_wdata,
  output logic [32*KANAL_SAYISI-1:0]           kanal_rdata,
  output logic                                 hata_o
);

  localparam int          IW        = $clog2(KANAL_SAYISI);
  localparam logic [31:0] HATA_VERI = 32'hDEAD_BEEF;

  if (KANAL_SAYISI < 2 || KANAL_SAYISI > 8) begin : g_k_chk
    $error("KANAL_SAYISI must be 2..8");
  end
  if (ZAMANASIMI < 1 || ZAMANASIMI > 65535) begin : g_z_chk
    $error("ZAMANASIMI must be 1..65535");
  end

  typedef enum logic [1:0] {
    BOSTA,
    ONCELIK,
    KANAL
  } durum_t;

  durum_t r_durum;
  durum_t w_durum_n;

  logic [IW-1:0] r_grant;
  logic [IW-1:0] w_grant_n;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_ptr_n;
  logic [IW-1:0] w_ptr_inc;
  logic [IW-1:0] w_secim;
  logic          w_bulundu;
  int            w_idx;

  logic                      w_g_valid;
  logic [3:0]                w_g_wstrb;
  logic [ADRES_GENISLIK-1:0] w_g_addr;
  logic [31:0]               w_g_wdata;
  logic [31:0]               w_g_baddr;
  logic                      w_tmo;

  // First requester at or above the pointer, wrapping around.
  always_comb begin
    w_bulundu = 1'b0;
    w_secim   = r_ptr;
    w_idx     = 0;
    for (int i = KANAL_SAYISI - 1; i >= 0; i--) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= KANAL_SAYISI) w_idx = w_idx - KANAL_SAYISI;
      if (kanal_valid[w_idx]) begin
        w_bulundu = 1'b1;
        w_secim   = IW'(w_idx);
      end
    end
  end

  always_comb begin
    w_g_valid = kanal_valid[r_grant];
    w_g_wstrb = kanal_wstrb[4*int'(r_grant) +: 4];
    w_g_addr  = kanal_addr[ADRES_GENISLIK*int'(r_grant) +: ADRES_GENISLIK];
    w_g_wdata = kanal_wdata[32*int'(r_grant) +: 32];
    w_g_baddr = '0;
    w_g_baddr[ADRES_GENISLIK+1:2] = w_g_addr;
    w_g_baddr = w_g_baddr | TABAN_ADRES;
  end

  assign w_ptr_inc = (int'(r_grant) == KANAL_SAYISI - 1) ?
                     '0 : r_grant + IW'(1);

`ifdef ANABELLEK_ZAMANASIMI_EN
  logic [15:0] r_sayac;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sayac <= '0;
    end else if (r_durum == BOSTA) begin
      r_sayac <= '0;
    end else if (!iomem_ready) begin
      r_sayac <= r_sayac + 16'd1;
    end
  end

  assign w_tmo = (r_durum != BOSTA) && !iomem_ready &&
                 (r_sayac == 16'(ZAMANASIMI));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_durum <= BOSTA;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_durum <= w_durum_n;
      r_grant <= w_grant_n;
      r_ptr   <= w_ptr_n;
    end
  end

  always_comb begin
    w_durum_n     = r_durum;
    w_grant_n     = r_grant;
    w_ptr_n       = r_ptr;
    iomem_valid   = 1'b0;
    iomem_wstrb   = 4'h0;
    iomem_addr    = '0;
    iomem_wdata   = w_g_wdata;
    oncelik_ready = 1'b0;
    oncelik_rdata = iomem_rdata;
    kanal_ready   = '0;
    kanal_rdata   = {KANAL_SAYISI{iomem_rdata}};
    hata_o        = 1'b0;
    unique case (r_durum)
      BOSTA: begin
        if (oncelik_valid) begin
          w_durum_n = ONCELIK;
        end else if (w_bulundu) begin
          w_durum_n = KANAL;
          w_grant_n = w_secim;
        end
      end
      ONCELIK: begin
        iomem_valid   = ~w_tmo;
        iomem_addr    = oncelik_addr;
        oncelik_ready = iomem_ready | w_tmo;
        hata_o        = w_tmo;
        if (w_tmo) oncelik_rdata = HATA_VERI;
        if (iomem_ready || w_tmo) w_durum_n = BOSTA;
      end
      KANAL: begin
        iomem_valid          = w_g_valid & ~w_tmo;
        iomem_wstrb          = w_g_wstrb;
        iomem_addr           = w_g_baddr;
        kanal_ready[r_grant] = iomem_ready | w_tmo;
        hata_o               = w_tmo;
        if (w_tmo) kanal_rdata[32*int'(r_grant) +: 32] = HATA_VERI;
        // A requester abandoning its request releases the grant unserved.
        if (w_tmo || (iomem_ready && w_g_valid)) begin
          w_durum_n = BOSTA;
          w_ptr_n   = w_ptr_inc;
        end else if (!w_g_valid) begin
          w_durum_n = BOSTA;
        end
      end
      default: w_durum_n = BOSTA;
    endcase
  end

endmodule

// File: tb/tb_anabellek_hakem.sv
// tb_anabellek_hakem: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_anabellek_hakem;

  localparam int K  = 4;
  localparam int AW = 17;
`ifdef ANABELLEK_ZAMANASIMI_EN
  localparam int ZT = 8;
`else
  localparam int ZT = 255;
`endif

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            iv;
  logic            rdy   = 1'b0;
  logic [3:0]      iws;
  logic [31:0]     ia;
  logic [31:0]     iwd;
  logic [31:0]     rdata = '0;
  logic            ov    = 1'b0;
  logic            oready;
  logic [31:0]     oa    = '0;
  logic [31:0]     ordata;
  logic [K-1:0]    kv    = '0;
  logic [K-1:0]    kr;
  logic [4*K-1:0]  kw    = '0;
  logic [AW*K-1:0] ka    = '0;
  logic [32*K-1:0] kd    = '0;
  logic [32*K-1:0] krd;
  logic            hata;

  int errors = 0;
  int checks = 0;

  anabellek_hakem #(
    .KANAL_SAYISI  (K),
    .ADRES_GENISLIK(AW),
    .TABAN_ADRES   (32'h4000_0000),
    .ZAMANASIMI    (ZT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .iomem_valid  (iv),
    .iomem_ready  (rdy),
    .iomem_wstrb  (iws),
    .iomem_addr   (ia),
    .iomem_wdata  (iwd),
    .iomem_rdata  (rdata),
    .oncelik_valid(ov),
    .oncelik_ready(oready),
    .oncelik_addr (oa),
    .oncelik_rdata(ordata),
    .kanal_valid  (kv),
    .kanal_ready  (kr),
    .kanal_wstrb  (kw),
    .kanal_addr   (ka),
    .kanal_wdata  (kd),
    .kanal_rdata  (krd),
    .hata_o       (hata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] baddr(input logic [16:0] a);
    return 32'h4000_0000 | {13'b0, a, 2'b00};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [16:0] a,
                        input logic [3:0] s, input logic [31:0] d);
    ka[AW*k +: AW] = a;
    kw[4*k +: 4]   = s;
    kd[32*k +: 32] = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    kv = '0; ov = 1'b0; rdy = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({iv, kr, oready, hata} !== 7'b0) begin
      errors++;
      $display("FAIL reset got v=%b kr=%b or=%b h=%b exp all 0",
               iv, kr, oready, hata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read_ch0;
    tick;
    set_ch(0, 17'h00010, 4'h0, 32'h0);
    kv = 4'b0001;
    @(negedge clk);
    checks++;
    if (iv !== 1'b0) begin
      errors++;
      $display("FAIL rd_lat got v=%b exp 0", iv);
    end
    tick;
    @(negedge clk);
    checks++;
    if ({iv, ia, iws} !== {1'b1, 32'h4000_0040, 4'h0}) begin
      errors++;
      $display("FAIL rd_req got v=%b a=%h s=%h exp 1 40000040 0",
               iv, ia, iws);
    end
    tick;
    tick;
    rdy = 1'b1;
    rdata = 32'hCAFE_0001;
    @(negedge clk);
    checks++;
    if ({kr, krd[31:0]} !== {4'b0001, 32'hCAFE_0001}) begin
      errors++;
      $display("FAIL rd_rdy got kr=%b d=%h exp 0001 cafe0001",
               kr, krd[31:0]);
    end
    tick;
    kv = '0;
    rdy = 1'b0;
    @(negedge clk);
    checks++;
    if ({iv, kr} !== 5'b0) begin
      errors++;
      $display("FAIL rd_idle got v=%b kr=%b exp 0 0000", iv, kr);
    end
  endtask

  task automatic test_drop;
    tick;
    set_ch(1, 17'h00123, 4'hF, 32'hA5A5_A5A5);
    kv = 4'b0010;
    @(negedge clk);
    tick;
    @(negedge clk);
    checks++;
    if ({iv, ia} !== {1'b1, baddr(17'h00123)}) begin
      errors++;
      $display("FAIL drop_grant got v=%b a=%h exp 1 %h",
               iv, ia, baddr(17'h00123));
    end
    tick;
    kv = '0;
    @(negedge clk);
    checks++;
    if ({iv, kr} !== 5'b0) begin
      errors++;
      $display("FAIL drop_same got v=%b kr=%b exp 0 0000", iv, kr);
    end
    tick;
    set_ch(0, 17'h00200, 4'h1, 32'h0);
    set_ch(2, 17'h00222, 4'h2, 32'h0);
    set_ch(3, 17'h00333, 4'h4, 32'h0);
    kv = 4'b1111;
    @(negedge clk);
    checks++;
    if (iv !== 1'b0) begin
      errors++;
      $display("FAIL drop_bosta got v=%b exp 0", iv);
    end
    tick;
    rdy = 1'b1;
    @(negedge clk);
    checks++;
    if ({ia, kr} !== {baddr(17'h00123), 4'b0010}) begin
      errors++;
      $display("FAIL drop_ptr got a=%h kr=%b exp %h 0010",
               ia, kr, baddr(17'h00123));
    end
    tick;
    kv = '0;
    rdy = 1'b0;
  endtask

  task automatic test_priority_mid;
    tick;
    set_ch(1, 17'h00456, 4'b0011, 32'h1234_5678);
    kv = 4'b0010;
    @(negedge clk);
    tick;
    oa = 32'h0200_0010;
    ov = 1'b1;
    @(negedge clk);
    checks++;
    if ({iv, ia, iws, iwd} !==
        {1'b1, baddr(17'h00456), 4'b0011, 32'h1234_5678}) begin
      errors++;
      $display("FAIL pri_wr got v=%b a=%h s=%h d=%h", iv, ia, iws, iwd);
    end
    tick;
    rdy = 1'b1;
    @(negedge clk);
    checks++;
    if ({ia, iws, kr, oready} !==
        {baddr(17'h00456), 4'b0011, 4'b0010, 1'b0}) begin
      errors++;
      $display("FAIL pri_nopreempt got a=%h s=%h kr=%b or=%b",
               ia, iws, kr, oready);
    end
    tick;
    kv = 4'b1111;
    rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (iv !== 1'b0) begin
      errors++;
      $display("FAIL pri_gap got v=%b exp 0", iv);
    end
    tick;
    rdy = 1'b1;
    rdata = 32'h0BAD_F00D;
    @(negedge clk);
    checks++;
    if ({iv, ia, iws, oready, kr} !==
        {1'b1, 32'h0200_0010, 4'h0, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL pri_req got v=%b a=%h s=%h or=%b kr=%b",
               iv, ia, iws, oready, kr);
    end
    checks++;
    if (ordata !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL pri_data got %h exp 0badf00d", ordata);
    end
    tick;
    ov = 1'b0;
    kv = '0;
    rdy = 1'b0;
  endtask

  task automatic test_rr;
    int e;
    tick;
    for (int k = 0; k < K; k++) set_ch(k, 17'(32'h100 + k), 4'(k), 32'(k));
    kv = 4'b1111;
    rdy = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      checks++;
      if (iv !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap n=%0d got v=%b exp 0", n, iv);
      end
      tick;
      rdy = 1'b1;
      e = (2 + n) % K;
      @(negedge clk);
      checks++;
      if ({ia, kr} !== {baddr(17'(32'h100 + e)), 4'(1 << e)}) begin
        errors++;
        $display("FAIL rr_grant n=%0d got a=%h kr=%b exp ch %0d",
                 n, ia, kr, e);
      end
      tick;
      rdy = 1'b0;
    end
  endtask

  task automatic test_async_reset;
    tick;
    @(negedge clk);
    checks++;
    if (iv !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre got v=%b exp 1", iv);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({iv, kr, oready} !== 6'b0) begin
      errors++;
      $display("FAIL ar_async got v=%b kr=%b or=%b exp 0", iv, kr, oready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({iv, ia} !== {1'b1, baddr(17'h00100)}) begin
      errors++;
      $display("FAIL ar_ptr0 got v=%b a=%h exp 1 %h",
               iv, ia, baddr(17'h00100));
    end
    tick;
    rdy = 1'b1;
    tick;
    kv = '0;
    rdy = 1'b0;
  endtask

  task automatic test_random;
    int cur;
    int ptr;
    int wcnt;
    int lat;
    int waits[K];
    logic         e_v;
    logic [31:0]  e_a;
    logic [3:0]   e_s;
    logic [K-1:0] e_kr;
    logic         e_or;
    rst_n = 1'b0;
    kv = '0; ov = 1'b0; rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cur = -1; ptr = 0; wcnt = 0; lat = 0;
    for (int k = 0; k < K; k++) waits[k] = 0;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      #1;
      // cur: -1 idle, -2 priority port, else granted channel
      if (cur == -1) begin
        if (ov) cur = -2;
        else
          for (int i = 0; i < K; i++)
            if (cur == -1 && kv[(ptr + i) % K]) cur = (ptr + i) % K;
        if (cur != -1) begin
          wcnt = 0;
          lat = $urandom_range(0, 2);
        end
      end else if (rdy) begin
        if (cur >= 0) begin
          for (int j = 0; j < K; j++)
            if (j != cur && kv[j]) begin
              waits[j]++;
              checks++;
              if (waits[j] > K - 1) begin
                errors++;
                $display("FAIL rnd_fair cyc=%0d ch=%0d waited %0d max %0d",
                         n, j, waits[j], K - 1);
              end
            end
          waits[cur] = 0;
          kv[cur] = 1'b0;
          ptr = (cur + 1) % K;
        end else begin
          ov = 1'b0;
        end
        cur = -1;
      end
      for (int k = 0; k < K; k++)
        if (!kv[k] && $urandom_range(0, 1) == 1) begin
          kv[k] = 1'b1;
          set_ch(k, 17'($urandom), 4'($urandom), $urandom);
        end
      if (!ov && $urandom_range(0, 7) == 0) begin
        ov = 1'b1;
        oa = $urandom;
      end
      rdy = (cur != -1) && (wcnt == lat);
      if (cur != -1) wcnt++;
      rdata = $urandom;
      @(negedge clk);
      e_v = (cur != -1);
      e_a = '0;
      e_s = '0;
      e_kr = '0;
      e_or = 1'b0;
      if (cur == -2) begin
        e_a = oa;
        e_or = rdy;
      end else if (cur >= 0) begin
        e_a = baddr(ka[AW*cur +: AW]);
        e_s = kw[4*cur +: 4];
        e_kr[cur] = rdy;
      end
      checks++;
      if (e_v ? ({iv, ia, iws} !== {e_v, e_a, e_s}) : (iv !== 1'b0)) begin
        errors++;
        $display("FAIL rnd_bus cyc=%0d got v=%b a=%h s=%h exp v=%b a=%h s=%h",
                 n, iv, ia, iws, e_v, e_a, e_s);
      end
      checks++;
      if ({kr, oready, hata} !== {e_kr, e_or, 1'b0}) begin
        errors++;
        $display("FAIL rnd_rdy cyc=%0d got kr=%b or=%b h=%b exp kr=%b or=%b h=0",
                 n, kr, oready, hata, e_kr, e_or);
      end
      if (cur >= 0) begin
        checks++;
        if ({iwd, krd[32*cur +: 32]} !== {kd[32*cur +: 32], rdata}) begin
          errors++;
          $display("FAIL rnd_data cyc=%0d got wd=%h rd=%h exp wd=%h rd=%h",
                   n, iwd, krd[32*cur +: 32], kd[32*cur +: 32], rdata);
        end
      end else if (cur == -2) begin
        checks++;
        if (ordata !== rdata) begin
          errors++;
          $display("FAIL rnd_odata cyc=%0d got %h exp %h", n, ordata, rdata);
        end
      end
    end
    tick;
    kv = '0;
    ov = 1'b0;
    rdy = 1'b0;
  endtask

`ifdef ANABELLEK_ZAMANASIMI_EN
  task automatic test_timeout;
    rst_n = 1'b0;
    kv = '0; ov = 1'b0; rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    set_ch(3, 17'h00777, 4'h0, 32'h0);
    kv = 4'b1000;
    @(negedge clk);
    for (int i = 0; i < ZT; i++) begin
      tick;
      @(negedge clk);
      checks++;
      if ({kr, hata} !== 5'b0) begin
        errors++;
        $display("FAIL to_wait i=%0d got kr=%b h=%b exp 0", i, kr, hata);
      end
    end
    tick;
    @(negedge clk);
    checks++;
    if ({kr, krd[127:96], hata, iv} !==
        {4'b1000, 32'hDEAD_BEEF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL to_fire got kr=%b d=%h h=%b v=%b",
               kr, krd[127:96], hata, iv);
    end
    tick;
    kv = '0;
    @(negedge clk);
    checks++;
    if (hata !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse got h=%b exp 0", hata);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_ch0();
    test_drop();
    test_priority_mid();
    test_rr();
    test_async_reset();
    test_random();
`ifdef ANABELLEK_ZAMANASIMI_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
